// File: rtl/exe_pkg.sv
// Shared definitions for the EXE-stage divide/remainder unit.
package exe_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, SPECIAL, RUN, FIX, DONE} div_state_t;

  // Magnitude of a two's-complement value; INT_MIN maps onto itself as unsigned 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left and try to subtract the divisor.
module div_step
  import exe_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] partial;
  logic [XLEN:0] trial;

  // rem < divisor keeps the partial remainder within 33 bits, so bit XLEN of trial is its sign.
  assign partial = {rem_i, quo_i[XLEN-1]};
  assign trial   = partial - {1'b0, divisor_i};
  assign rem_o   = trial[XLEN] ? partial[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/exe_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with a start/busy/done handshake.
module exe_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import exe_pkg::*;

  div_state_t      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            isRem_q, isRem_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;

  logic [XLEN-1:0] stepRem, stepQuo;
  logic            isSigned, isSpecial;

  div_step u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvsr_q),
    .rem_o    (stepRem),
    .quo_o    (stepQuo)
  );

  assign isSigned  = ~funct3[0];
  assign isSpecial = (rb == '0) || (isSigned && (rs1 == INT_MIN) && (rb == '1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      isRem_q  <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      isRem_q  <= isRem_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    isRem_d  = isRem_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;

    unique case (state_q)
      IDLE: begin
        if (start && funct3[2] && !flush) begin
          isRem_d = funct3[1];
          cnt_d   = '0;
          if (isSpecial) begin
            // Raw operands are kept so REM by zero can return the signed dividend untouched.
            state_d = SPECIAL;
            rem_d   = rs1;
            quo_d   = '0;
            dvsr_d  = rb;
            negQ_d  = 1'b0;
            negR_d  = 1'b0;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            quo_d   = isSigned ? abs_val(rs1) : rs1;
            dvsr_d  = isSigned ? abs_val(rb) : rb;
            negQ_d  = isSigned & (rs1[XLEN-1] ^ rb[XLEN-1]);
            negR_d  = isSigned & rs1[XLEN-1];
          end
        end
      end
      SPECIAL: begin
        state_d = DONE;
        if (dvsr_q == '0) result_d = isRem_q ? rem_q : DIV0_QUOT;
        else              result_d = isRem_q ? '0 : INT_MIN;
      end
      RUN: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (isRem_q) result_d = negR_q ? (~rem_q + 1'b1) : rem_q;
        else         result_d = negQ_q ? (~quo_q + 1'b1) : quo_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An abort leaves the previously delivered result visible.
    if (flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  assign busy   = (state_q == SPECIAL) || (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed-vector bench for exe_div_unit: arithmetic, special cases, flush, reset and busy handling.
module tb_exe_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  exe_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct3(funct3),
    .rs1   (rs1),
    .rb    (rb),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one op and wait for done; edge count includes the accepting edge.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int edges, output bit busyOk,
                        output bit pulseOk);
    start = 1'b1; funct3 = f3; rs1 = a; rb = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rb = $urandom;
    edges = 1; busyOk = 1'b1;
    while (!done && edges < 100) begin
      if (!busy) busyOk = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    res = result;
    if (busy) busyOk = 1'b0;
    @(posedge clk); #1;
    pulseOk = !done && !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int e; bit b, p;
    run_op(3'b101, 32'd100, 32'd7, r, e, b, p);
    vectors++; if (r !== 32'd14) begin errors++; $display("[TB] FAIL divu_100_7: got %h expected %h", r, 32'd14); end
    vectors++; if (e !== 34) begin errors++; $display("[TB] FAIL divu_latency: got %0d expected 34", e); end
    vectors++; if (!b) begin errors++; $display("[TB] FAIL divu_busy: got drop expected busy throughout"); end
    vectors++; if (!p) begin errors++; $display("[TB] FAIL divu_done_pulse: got long pulse expected one cycle"); end
    run_op(3'b111, 32'd100, 32'd7, r, e, b, p);
    vectors++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL remu_100_7: got %h expected %h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int e; bit b, p;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_m7_2: got %h expected FFFFFFFD", r); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_m7_2: got %h expected FFFFFFFF", r); end
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_7_m2: got %h expected FFFFFFFD", r); end
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, r, e, b, p);
    vectors++; if (r !== 32'd1) begin errors++; $display("[TB] FAIL rem_7_m2: got %h expected 00000001", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int e; bit b, p;
    run_op(3'b100, 32'd5, 32'd0, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_5_0: got %h expected FFFFFFFF", r); end
    vectors++; if (e !== 2) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected 2", e); end
    vectors++; if (!b) begin errors++; $display("[TB] FAIL div0_busy: got drop expected busy in SPECIAL"); end
    run_op(3'b111, 32'd5, 32'd0, r, e, b, p);
    vectors++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL remu_5_0: got %h expected 00000005", r); end
    run_op(3'b101, 32'd0, 32'd0, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_0_0: got %h expected FFFFFFFF", r); end
    run_op(3'b110, 32'h8000_0001, 32'd0, r, e, b, p);
    vectors++; if (r !== 32'h8000_0001) begin errors++; $display("[TB] FAIL rem_neg_0: got %h expected 80000001", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int e; bit b, p;
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, e, b, p);
    vectors++; if (r !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_ovf: got %h expected 80000000", r); end
    vectors++; if (e !== 2) begin errors++; $display("[TB] FAIL div_ovf_latency: got %0d expected 2", e); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, e, b, p);
    vectors++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rem_ovf: got %h expected 00000000", r); end
    // Unsigned 2^31 / (2^32-1) is an ordinary division: quotient 0, remainder 2^31.
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, r, e, b, p);
    vectors++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL divu_ovf_ops: got %h expected 00000000", r); end
    vectors++; if (e !== 34) begin errors++; $display("[TB] FAIL divu_ovf_latency: got %0d expected 34", e); end
    run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, r, e, b, p);
    vectors++; if (r !== 32'h8000_0000) begin errors++; $display("[TB] FAIL remu_ovf_ops: got %h expected 80000000", r); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int e; bit b, p, sawDone;
    run_op(3'b101, 32'd50, 32'd5, r, e, b, p);
    vectors++; if (r !== 32'd10) begin errors++; $display("[TB] FAIL divu_50_5: got %h expected 0000000A", r); end
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd1000; rb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    vectors++; if (sawDone) begin errors++; $display("[TB] FAIL flush_no_done: got pulse expected none"); end
    vectors++; if (result !== 32'd10) begin errors++; $display("[TB] FAIL flush_result_kept: got %h expected 0000000A", result); end
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_flush_ignored: got busy %b expected 0", busy); end
    start = 1'b1; funct3 = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL non_div_ignored: got busy %b expected 0", busy); end
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1, r, e, b, p);
    vectors++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_max_1: got %h expected FFFFFFFF", r); end
    vectors++; if (e !== 34) begin errors++; $display("[TB] FAIL divu_max_latency: got %0d expected 34", e); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    vectors++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL midrst_result: got %h expected 00000000", result); end
  endtask

  task automatic test_back_to_back();
    int e;
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rb = 32'd7;
    @(posedge clk); #1;
    funct3 = 3'b111; rs1 = 32'd1000; rb = 32'd3;
    e = 1;
    while (!done && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    vectors++; if (result !== 32'd14) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected 0000000E", result); end
    vectors++; if (e !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", e); end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_start_ignored: got busy %b expected 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; rs1 = '0; rb = '0; flush = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
